// File: rtl/cpu_mem_if_if.sv
// ---------------------------------------------------------------------------
// CpuMemIfIf: signal bundle between a small CPU core, its memory, and the
// cpu_mem_if access sequencer.
//
// Contents:
//   CPU request side : fetch, ld, st, da_in, wdata, pc_load, pc_mode,
//                      pc_off, pc_tgt
//   Memory side      : mem_rdata, mem_rdy (into the sequencer),
//                      mem_cmd, mem_addr, mem_wdata (out of the sequencer)
//   Status side      : pc, ir, rdata, busy, done, err
//
// Modports:
//   slave  - the cpu_mem_if sequencer itself
//   master - the surrounding environment (core plus memory model)
// ---------------------------------------------------------------------------
interface cpu_mem_if_if #(
    parameter int AW = 9,
    parameter int DW = 16
);
    logic          fetch;
    logic          ld;
    logic          st;
    logic [AW-1:0] da_in;
    logic [DW-1:0] wdata;
    logic          pc_load;
    logic [1:0]    pc_mode;
    logic [AW-1:0] pc_off;
    logic [AW-1:0] pc_tgt;
    logic [DW-1:0] mem_rdata;
    logic          mem_rdy;
    logic [1:0]    mem_cmd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] pc;
    logic [DW-1:0] ir;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          done;
    logic          err;

    modport slave (
        input  fetch, ld, st, da_in, wdata, pc_load, pc_mode, pc_off, pc_tgt,
        input  mem_rdata, mem_rdy,
        output mem_cmd, mem_addr, mem_wdata,
        output pc, ir, rdata, busy, done, err
    );

    modport master (
        output fetch, ld, st, da_in, wdata, pc_load, pc_mode, pc_off, pc_tgt,
        output mem_rdata, mem_rdy,
        input  mem_cmd, mem_addr, mem_wdata,
        input  pc, ir, rdata, busy, done, err
    );
endinterface

// File: rtl/cpu_mem_if.sv
// ---------------------------------------------------------------------------
// cpu_mem_if: single-outstanding-access sequencer between a CPU core and a
// memory with a ready handshake.  It owns the program counter, the
// instruction register and the load-data register.
//
// Ports:
//   clk   - sole clock, everything updates on its rising edge
//   reset - synchronous, active-low
//   bus   - cpu_mem_if_if.slave bundle (requests, memory handshake, status)
//
// Behaviour summary:
//   IDLE takes one action per cycle (pc_load > st > ld > fetch).  A memory
//   access holds mem_cmd until mem_rdy, then pulses done.  If the memory
//   stays not-ready for MAX_WAIT cycles, the access is dropped and err
//   pulses instead.
// ---------------------------------------------------------------------------
module cpu_mem_if #(
    parameter int            AW       = 9,
    parameter int            DW       = 16,
    parameter logic [AW-1:0] RST_PC   = '0,
    parameter int            MAX_WAIT = 15
) (
    input  logic         clk,
    input  logic         reset,
    cpu_mem_if_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;
    localparam logic [1:0] S_STORE = 2'd3;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    // The counter holds the number of not-ready cycles already seen, so the
    // access is abandoned on the not-ready cycle that would make it MAX_WAIT.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    logic [1:0]    r_state;
    logic [AW-1:0] r_pc;
    logic [DW-1:0] r_ir;
    logic [DW-1:0] r_rdata;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [7:0]    r_wait;
    logic          r_done;
    logic          r_err;

    logic [AW-1:0] w_pc_next;
    logic [1:0]    w_cmd;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    logic          w_busy;

    assign w_busy = (r_state != S_IDLE);

    // PC update value selected by pc_mode.  All sums are AW bits wide, so
    // they wrap naturally modulo 2^AW, including negative offsets.
    always_comb begin
        w_pc_next = r_pc;
        case (bus.pc_mode)
            2'b00:   w_pc_next = r_pc + AW'(1);
            2'b01:   w_pc_next = r_pc + AW'(1) + bus.pc_off;
            2'b10:   w_pc_next = bus.pc_tgt;
            default: w_pc_next = RST_PC;
        endcase
    end

    // Main state register.  IDLE arbitrates the incoming requests and
    // latches the address and store data; the busy states wait for mem_rdy,
    // which beats the timeout when both land on the same cycle.  done and
    // err default low every cycle so each is a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_pc    <= RST_PC;
            r_ir    <= '0;
            r_rdata <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wait  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (r_state == S_IDLE) begin
                if (bus.pc_load) begin
                    r_pc <= w_pc_next;
                end else if (bus.st || bus.ld || bus.fetch) begin
                    r_addr  <= bus.da_in;
                    r_wdata <= bus.wdata;
                    r_wait  <= '0;
                    if (bus.st) begin
                        r_state <= S_STORE;
                    end else if (bus.ld) begin
                        r_state <= S_LOAD;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
            end else if (bus.mem_rdy) begin
                if (r_state == S_FETCH) begin
                    r_ir <= bus.mem_rdata;
                    r_pc <= r_pc + AW'(1);
                end else if (r_state == S_LOAD) begin
                    r_rdata <= bus.mem_rdata;
                end
                r_done  <= 1'b1;
                r_state <= S_IDLE;
            end else begin
                r_wait <= r_wait + 8'd1;
                if (r_wait == WAIT_LAST) begin
                    r_err   <= 1'b1;
                    r_state <= S_IDLE;
                end
            end
        end
    end

    // Memory-side outputs decode straight from the state so they change on
    // the same edge that enters or leaves a busy state; IDLE drives zeros.
    always_comb begin
        w_cmd   = CMD_NONE;
        w_addr  = '0;
        w_wdata = '0;
        case (r_state)
            S_FETCH: begin
                w_cmd  = CMD_READ;
                w_addr = r_pc;
            end
            S_LOAD: begin
                w_cmd  = CMD_READ;
                w_addr = r_addr;
            end
            S_STORE: begin
                w_cmd   = CMD_WRITE;
                w_addr  = r_addr;
                w_wdata = r_wdata;
            end
            default: begin
                w_cmd   = CMD_NONE;
                w_addr  = '0;
                w_wdata = '0;
            end
        endcase
    end

    assign bus.mem_cmd   = w_cmd;
    assign bus.mem_addr  = w_addr;
    assign bus.mem_wdata = w_wdata;
    assign bus.pc        = r_pc;
    assign bus.ir        = r_ir;
    assign bus.rdata     = r_rdata;
    assign bus.busy      = w_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_cpu_mem_if.sv
// ---------------------------------------------------------------------------
// tb_cpu_mem_if: directed testbench for cpu_mem_if with the default
// parameters (AW=9, DW=16, RST_PC=0, MAX_WAIT=15).  A table of vectors with
// hand-computed expected outputs is applied one clock at a time, followed by
// hand-written sequences for the timeout and the timeout-versus-ready tie.
// ---------------------------------------------------------------------------
module tb_cpu_mem_if;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    cpu_mem_if_if #(.AW(9), .DW(16)) bus ();

    cpu_mem_if #(
        .AW       (9),
        .DW       (16),
        .RST_PC   (9'h000),
        .MAX_WAIT (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        fetch;
        logic        ld;
        logic        st;
        logic        pcLoad;
        logic [1:0]  pcMode;
        logic [8:0]  pcOff;
        logic [8:0]  pcTgt;
        logic [8:0]  daIn;
        logic [15:0] wdata;
        logic [15:0] memRdata;
        logic        memRdy;
        logic [1:0]  expCmd;
        logic [8:0]  expAddr;
        logic [15:0] expWdata;
        logic [8:0]  expPc;
        logic [15:0] expIr;
        logic [15:0] expRdata;
        logic        expBusy;
        logic        expDone;
        logic        expErr;
    } vec_t;

    vec_t vecs[$];

    // Appends one row: stimulus for the next edge, then the outputs
    // expected just after that edge.
    task automatic addVec(
        input string name,
        input logic rst, input logic f, input logic l, input logic s,
        input logic pl, input logic [1:0] pm, input logic [8:0] off,
        input logic [8:0] tgt, input logic [8:0] da, input logic [15:0] wd,
        input logic [15:0] mrd, input logic rdy,
        input logic [1:0] eCmd, input logic [8:0] eAddr,
        input logic [15:0] eWd, input logic [8:0] ePc,
        input logic [15:0] eIr, input logic [15:0] eRd,
        input logic eBusy, input logic eDone, input logic eErr);
        vec_t v;
        v.name = name;     v.rst = rst;       v.fetch = f;
        v.ld = l;          v.st = s;          v.pcLoad = pl;
        v.pcMode = pm;     v.pcOff = off;     v.pcTgt = tgt;
        v.daIn = da;       v.wdata = wd;      v.memRdata = mrd;
        v.memRdy = rdy;    v.expCmd = eCmd;   v.expAddr = eAddr;
        v.expWdata = eWd;  v.expPc = ePc;     v.expIr = eIr;
        v.expRdata = eRd;  v.expBusy = eBusy; v.expDone = eDone;
        v.expErr = eErr;
        vecs.push_back(v);
    endtask

    // Drives inputs on the falling edge, lets one rising edge pass, and
    // returns 1 time unit later so outputs are sampled away from the edge.
    task automatic applyStimulus(
        input logic rst, input logic f, input logic l, input logic s,
        input logic pl, input logic [1:0] pm, input logic [8:0] off,
        input logic [8:0] tgt, input logic [8:0] da, input logic [15:0] wd,
        input logic [15:0] mrd, input logic rdy);
        @(negedge clk);
        reset         = rst;
        bus.fetch     = f;
        bus.ld        = l;
        bus.st        = s;
        bus.pc_load   = pl;
        bus.pc_mode   = pm;
        bus.pc_off    = off;
        bus.pc_tgt    = tgt;
        bus.da_in     = da;
        bus.wdata     = wd;
        bus.mem_rdata = mrd;
        bus.mem_rdy   = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Short helper for the hand-written sequences: a plain memory cycle
    // with no PC request and reset released.
    task automatic memCycle(input logic f, input logic l, input logic s,
                            input logic [8:0] da, input logic [15:0] wd,
                            input logic [15:0] mrd, input logic rdy);
        applyStimulus(1'b1, f, l, s, 1'b0, 2'b00, 9'h0, 9'h0, da, wd, mrd, rdy);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b0;
        bus.fetch     = 1'b0;
        bus.ld        = 1'b0;
        bus.st        = 1'b0;
        bus.pc_load   = 1'b0;
        bus.pc_mode   = 2'b00;
        bus.pc_off    = '0;
        bus.pc_tgt    = '0;
        bus.da_in     = '0;
        bus.wdata     = '0;
        bus.mem_rdata = '0;
        bus.mem_rdy   = 1'b0;

        //     name             rst f l s pl mode  off     tgt     da      wd         mrd        rdy | cmd   addr    wd         pc      ir         rd         b d e
        addVec("reset",         0, 0,0,0,0, 2'd0, 9'h000, 9'h000, 9'h000, 16'h0000, 16'h0000, 0,  2'd0, 9'h000, 16'h0000, 9'h000, 16'h0000, 16'h0000, 0,0,0);
        addVec("fetchAccept",   1, 1,0,0,0, 2'd0, 9'h000, 9'h000, 9'h000, 16'h0000, 16'hA5A5, 1,  2'd1, 9'h000, 16'h0000, 9'h000, 16'h0000, 16'h0000, 1,0,0);
        addVec("fetchDone",     1, 0,0,0,0, 2'd0, 9'h000, 9'h000, 9'h000, 16'h0000, 16'hA5A5, 1,  2'd0, 9'h000, 16'h0000, 9'h001, 16'hA5A5, 16'h0000, 0,1,0);
        addVec("idleQuiet",     1, 0,0,0,0, 2'd0, 9'h000, 9'h000, 9'h000, 16'h0000, 16'h0000, 0,  2'd0, 9'h000, 16'h0000, 9'h001, 16'hA5A5, 16'h0000, 0,0,0);
        addVec("pcTgtTop",      1, 0,0,0,1, 2'd2, 9'h000, 9'h1FF, 9'h000, 16'h0000, 16'h0000, 0,  2'd0, 9'h000, 16'h0000, 9'h1FF, 16'hA5A5, 16'h0000, 0,0,0);
        addVec("fetchTop",      1, 1,0,0,0, 2'd0, 9'h000, 9'h000, 9'h000, 16'h0000, 16'h0000, 0,  2'd1, 9'h1FF, 16'h0000, 9'h1FF, 16'hA5A5, 16'h0000, 1,0,0);
        addVec("fetchWrap",     1, 0,0,0,0, 2'd0, 9'h000, 9'h000, 9'h000, 16'h0000, 16'h0F0F, 1,  2'd0, 9'h000, 16'h0000, 9'h000, 16'h0F0F, 16'h0000, 0,1,0);
        addVec("pcTgt5",        1, 0,0,0,1, 2'd2, 9'h000, 9'h005, 9'h000, 16'h0000, 16'h0000, 0,  2'd0, 9'h000, 16'h0000, 9'h005, 16'h0F0F, 16'h0000, 0,0,0);
        addVec("pcBranchNeg",   1, 0,0,0,1, 2'd1, 9'h1FE, 9'h000, 9'h000, 16'h0000, 16'h0000, 0,  2'd0, 9'h000, 16'h0000, 9'h004, 16'h0F0F, 16'h0000, 0,0,0);
        addVec("pcInc",         1, 0,0,0,1, 2'd0, 9'h000, 9'h000, 9'h000, 16'h0000, 16'h0000, 0,  2'd0, 9'h000, 16'h0000, 9'h005, 16'h0F0F, 16'h0000, 0,0,0);
        addVec("pcRstMode",     1, 0,0,0,1, 2'd3, 9'h000, 9'h000, 9'h000, 16'h0000, 16'h0000, 0,  2'd0, 9'h000, 16'h0000, 9'h000, 16'h0F0F, 16'h0000, 0,0,0);
        addVec("pcBranchWrap",  1, 0,0,0,1, 2'd1, 9'h1FC, 9'h000, 9'h000, 16'h0000, 16'h0000, 0,  2'd0, 9'h000, 16'h0000, 9'h1FD, 16'h0F0F, 16'h0000, 0,0,0);
        addVec("priorityAll",   1, 1,1,1,1, 2'd0, 9'h000, 9'h000, 9'h033, 16'hBEEF, 16'h0000, 0,  2'd0, 9'h000, 16'h0000, 9'h1FE, 16'h0F0F, 16'h0000, 0,0,0);
        addVec("ldAccept",      1, 0,1,0,0, 2'd0, 9'h000, 9'h000, 9'h044, 16'h0000, 16'h0000, 0,  2'd1, 9'h044, 16'h0000, 9'h1FE, 16'h0F0F, 16'h0000, 1,0,0);
        addVec("ldBusyIgnore",  1, 0,0,1,1, 2'd2, 9'h000, 9'h077, 9'h055, 16'h1111, 16'h0000, 0,  2'd1, 9'h044, 16'h0000, 9'h1FE, 16'h0F0F, 16'h0000, 1,0,0);
        addVec("ldDone",        1, 0,0,0,0, 2'd0, 9'h000, 9'h000, 9'h000, 16'h0000, 16'hC3C3, 1,  2'd0, 9'h000, 16'h0000, 9'h1FE, 16'h0F0F, 16'hC3C3, 0,1,0);
        addVec("stAccept",      1, 0,0,1,0, 2'd0, 9'h000, 9'h000, 9'h020, 16'h1234, 16'hFFFF, 1,  2'd2, 9'h020, 16'h1234, 9'h1FE, 16'h0F0F, 16'hC3C3, 1,0,0);
        addVec("stWait1",       1, 0,0,0,0, 2'd0, 9'h000, 9'h000, 9'h000, 16'h0000, 16'hFFFF, 0,  2'd2, 9'h020, 16'h1234, 9'h1FE, 16'h0F0F, 16'hC3C3, 1,0,0);
        addVec("stWait2",       1, 0,0,0,0, 2'd0, 9'h000, 9'h000, 9'h000, 16'h0000, 16'hFFFF, 0,  2'd2, 9'h020, 16'h1234, 9'h1FE, 16'h0F0F, 16'hC3C3, 1,0,0);
        addVec("stWait3",       1, 0,0,0,0, 2'd0, 9'h000, 9'h000, 9'h000, 16'h0000, 16'hFFFF, 0,  2'd2, 9'h020, 16'h1234, 9'h1FE, 16'h0F0F, 16'hC3C3, 1,0,0);
        addVec("stDone",        1, 0,0,0,0, 2'd0, 9'h000, 9'h000, 9'h000, 16'h0000, 16'hFFFF, 1,  2'd0, 9'h000, 16'h0000, 9'h1FE, 16'h0F0F, 16'hC3C3, 0,1,0);
        addVec("ldAccept2",     1, 0,1,0,0, 2'd0, 9'h000, 9'h000, 9'h0AA, 16'h0000, 16'h0000, 0,  2'd1, 9'h0AA, 16'h0000, 9'h1FE, 16'h0F0F, 16'hC3C3, 1,0,0);
        addVec("resetInLoad",   0, 1,0,0,0, 2'd0, 9'h000, 9'h000, 9'h000, 16'h0000, 16'h5555, 1,  2'd0, 9'h000, 16'h0000, 9'h000, 16'h0000, 16'h0000, 0,0,0);
        addVec("afterReset",    1, 0,0,0,0, 2'd0, 9'h000, 9'h000, 9'h000, 16'h0000, 16'h0000, 0,  2'd0, 9'h000, 16'h0000, 9'h000, 16'h0000, 16'h0000, 0,0,0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].fetch, vecs[i].ld, vecs[i].st,
                          vecs[i].pcLoad, vecs[i].pcMode, vecs[i].pcOff,
                          vecs[i].pcTgt, vecs[i].daIn, vecs[i].wdata,
                          vecs[i].memRdata, vecs[i].memRdy);
            checkOutput({vecs[i].name, ".mem_cmd"},   32'(bus.mem_cmd),   32'(vecs[i].expCmd));
            checkOutput({vecs[i].name, ".mem_addr"},  32'(bus.mem_addr),  32'(vecs[i].expAddr));
            checkOutput({vecs[i].name, ".mem_wdata"}, 32'(bus.mem_wdata), 32'(vecs[i].expWdata));
            checkOutput({vecs[i].name, ".pc"},        32'(bus.pc),        32'(vecs[i].expPc));
            checkOutput({vecs[i].name, ".ir"},        32'(bus.ir),        32'(vecs[i].expIr));
            checkOutput({vecs[i].name, ".rdata"},     32'(bus.rdata),     32'(vecs[i].expRdata));
            checkOutput({vecs[i].name, ".busy"},      32'(bus.busy),      32'(vecs[i].expBusy));
            checkOutput({vecs[i].name, ".done"},      32'(bus.done),      32'(vecs[i].expDone));
            checkOutput({vecs[i].name, ".err"},       32'(bus.err),       32'(vecs[i].expErr));
        end

        // Timeout: load a known value into rdata, then start a load that the
        // memory never answers.  Fourteen not-ready cycles stay busy; the
        // fifteenth drops back to IDLE with a single err pulse.
        memCycle(0, 1, 0, 9'h010, 16'h0000, 16'h0000, 0);
        memCycle(0, 0, 0, 9'h000, 16'h0000, 16'h7E7E, 1);
        checkOutput("preload.rdata", 32'(bus.rdata), 32'h7E7E);
        checkOutput("preload.done",  32'(bus.done),  32'h1);
        memCycle(0, 1, 0, 9'h011, 16'h0000, 16'hDEAD, 0);
        checkOutput("toAccept.busy", 32'(bus.busy), 32'h1);
        for (int k = 1; k <= 14; k++) begin
            memCycle(0, 0, 0, 9'h000, 16'h0000, 16'hDEAD, 0);
            checkOutput($sformatf("toWait%0d.busy", k), 32'(bus.busy), 32'h1);
            checkOutput($sformatf("toWait%0d.err", k),  32'(bus.err),  32'h0);
        end
        memCycle(0, 0, 0, 9'h000, 16'h0000, 16'hDEAD, 0);
        checkOutput("timeout.err",     32'(bus.err),     32'h1);
        checkOutput("timeout.done",    32'(bus.done),    32'h0);
        checkOutput("timeout.busy",    32'(bus.busy),    32'h0);
        checkOutput("timeout.mem_cmd", 32'(bus.mem_cmd), 32'h0);
        checkOutput("timeout.rdata",   32'(bus.rdata),   32'h7E7E);
        checkOutput("timeout.pc",      32'(bus.pc),      32'h0);
        memCycle(0, 0, 0, 9'h000, 16'h0000, 16'h0000, 0);
        checkOutput("afterTimeout.err", 32'(bus.err), 32'h0);

        // Tie: a fetch whose ready arrives on the cycle that would otherwise
        // time out must complete normally.
        memCycle(1, 0, 0, 9'h000, 16'h0000, 16'h0000, 0);
        checkOutput("tieAccept.mem_cmd", 32'(bus.mem_cmd), 32'h1);
        for (int k = 1; k <= 14; k++) begin
            memCycle(0, 0, 0, 9'h000, 16'h0000, 16'h0000, 0);
        end
        checkOutput("tieWaiting.busy", 32'(bus.busy), 32'h1);
        memCycle(0, 0, 0, 9'h000, 16'h0000, 16'h9999, 1);
        checkOutput("tie.done", 32'(bus.done), 32'h1);
        checkOutput("tie.err",  32'(bus.err),  32'h0);
        checkOutput("tie.ir",   32'(bus.ir),   32'h9999);
        checkOutput("tie.pc",   32'(bus.pc),   32'h1);
        checkOutput("tie.busy", 32'(bus.busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_mem_if.md
CPU_MEM_IF -- requirements
Module: cpu_mem_if

Interface
REQ-001 AW, default 9: width of the PC, data address and memory address.
REQ-002 DW, default 16: width of the instruction and data words.
REQ-003 RST_PC, default 0: value loaded into PC on reset.
REQ-004 MAX_WAIT, default 15: maximum number of not-ready cycles before an access is aborted; legal range 1..255.
REQ-005 clk  in  1  sole clock; all state updates on posedge clk.
REQ-006 reset  in  1  synchronous, active-low reset (reset==0 at posedge resets).
REQ-007 fetch  in  1  request an instruction read at the current PC.
REQ-008 ld  in  1  request a data read at da_in.
REQ-009 st  in  1  request a data write of wdata at da_in.
REQ-010 da_in  in  AW  data address; sampled when a request is accepted.
REQ-011 wdata  in  DW  store data; sampled when a request is accepted.
REQ-012 pc_load  in  1  PC update request.
REQ-013 pc_mode  in  2  PC update mode: 00 = PC+1; 01 = PC+1+pc_off; 10 = pc_tgt; 11 = RST_PC.
REQ-014 pc_off  in  AW  two's-complement branch offset.
REQ-015 pc_tgt  in  AW  absolute branch target.
REQ-016 mem_rdata  in  DW  memory read data; valid when mem_rdy=1.
REQ-017 mem_rdy  in  1  memory accepts or completes the current access in this cycle.
REQ-018 mem_cmd  out  2  00 = NONE, 01 = READ, 10 = WRITE; 11 is never driven.
REQ-019 mem_addr  out  AW  memory address.
REQ-020 mem_wdata  out  DW  write data.
REQ-021 pc  out  AW  program counter.
REQ-022 ir  out  DW  last fetched instruction.
REQ-023 rdata  out  DW  last loaded data word.
REQ-024 busy  out  1  high in every state other than IDLE.
REQ-025 done  out  1  one-cycle pulse when an access completes successfully.
REQ-026 err  out  1  one-cycle pulse when an access times out.

Function
REQ-027 The block SHALL implement the FSM states IDLE, FETCH, LOAD and STORE.
REQ-028 IDLE SHALL accept at most one action per cycle, in priority order pc_load > st > ld > fetch; lower-priority requests in the same cycle are dropped, not queued.
REQ-029 In IDLE, pc_load SHALL update pc at that clock edge per pc_mode, with the state remaining IDLE.
REQ-030 A request accepted at edge T SHALL latch da_in and wdata into internal registers and enter the corresponding state, driving mem_cmd from cycle T+1.
REQ-031 In FETCH, mem_cmd=READ and mem_addr=pc; in LOAD, mem_cmd=READ and mem_addr=latched address; in STORE, mem_cmd=WRITE, mem_addr=latched address and mem_wdata=latched data.
REQ-032 In IDLE, mem_cmd=NONE, mem_addr=0 and mem_wdata=0; outputs SHALL never be X.
REQ-033 When mem_rdy=1 in FETCH, the block SHALL, at that edge, load ir<=mem_rdata, increment pc by 1, assert done for the next cycle and return to IDLE.
REQ-034 When mem_rdy=1 in LOAD, the block SHALL load rdata<=mem_rdata, assert done and return to IDLE; pc is unchanged.
REQ-035 When mem_rdy=1 in STORE, the block SHALL assert done and return to IDLE; ir, rdata and pc are unchanged.
REQ-036 The minimum latency from request accept to done SHALL be 2 cycles: accept at T, mem_rdy at T+1, done high in cycle T+2.
REQ-037 A wait counter SHALL clear on accept and increment on each busy cycle with mem_rdy=0.
REQ-038 If the wait counter reaches MAX_WAIT with mem_rdy=0, the block SHALL return to IDLE, pulse err for one cycle and update no architectural register.
REQ-039 If mem_rdy=1 and the counter limit occur in the same cycle, mem_rdy SHALL win (completion, no err).
REQ-040 All PC arithmetic SHALL be modulo 2^AW: all-ones+1 wraps to 0, and negative pc_off wraps below 0.
REQ-041 fetch, ld, st and pc_load SHALL be ignored while busy=1.
REQ-042 done and err SHALL never be high in the same cycle.

Reset
REQ-043 When reset==0 at a clock edge, the block SHALL set: state=IDLE; pc=RST_PC; ir=0; rdata=0; internal address and data registers=0; wait counter=0; done=0; err=0; mem_cmd=NONE.
REQ-044 Reset SHALL abort an in-flight access with no done or err and no update to ir, rdata or pc.
REQ-045 Reset SHALL take priority over every request and over mem_rdy in the same cycle.

Verification
REQ-046 Reset, then fetch with mem_rdy=1 and mem_rdata=16'hA5A5 -> T+1: mem_cmd=01, mem_addr=0; T+2: ir=A5A5, pc=1, done=1.
REQ-047 pc=9'h1FF, fetch, mem_rdy=1 -> pc wraps to 0; pc=5, pc_load with mode 01 and pc_off=9'h1FE (-2) -> pc=4.
REQ-048 st with da_in=9'h020 and wdata=16'h1234, mem_rdy held low 3 cycles -> mem_cmd=10 and mem_addr=020 stable for 4 cycles, then done=1.
REQ-049 ld with mem_rdy never asserted and MAX_WAIT=15 -> err pulses one cycle after 15 wait cycles; rdata is unchanged and busy drops.
REQ-050 pc_load, st and fetch asserted together in IDLE -> only the PC update occurs; busy stays 0.
REQ-051 reset=0 during a LOAD wait state -> next cycle: IDLE, mem_cmd=00, pc=RST_PC, no done or err.
